// File: rtl/gcd_pkg.sv
// Shared types and sizing for the Stein GCD engine.
// The optional cycle counter is enabled with GCD_CYCLE_COUNT_EN.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    REDUCE,
    FINISH,
    DONE
  } gcd_state_t;

  // Wide enough for the worst case ALIGN + REDUCE + FINISH cycle count.
  function automatic int cnt_width(input int width);
    return $clog2(3 * width + 4);
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One REDUCE iteration of Stein's binary GCD: strip a factor of two from an
// even operand, otherwise replace the larger odd operand by half the difference.
module gcd_stein_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x_nx,
  output logic [WIDTH-1:0] y_nx,
  output logic             eq
);

  always_comb begin
    x_nx = x;
    y_nx = y;
    eq   = 1'b0;
    if (!x[0]) begin
      x_nx = x >> 1;
    end else if (!y[0]) begin
      y_nx = y >> 1;
    end else if (x == y) begin
      eq = 1'b1;
    end else if (x > y) begin
      // Both odd, so the difference is even and the halving is exact.
      x_nx = (x - y) >> 1;
    end else begin
      y_nx = (y - x) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stein_engine.sv
// Binary (Stein) GCD engine with valid/ready operand and result handshakes.
// Define GCD_CYCLE_COUNT_EN to add the saturating compute-cycle counter on out_cycles.
module gcd_stein_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef GCD_CYCLE_COUNT_EN
  ,
  localparam int CNT_W = cnt_width(WIDTH)
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] out_cycles
`endif
);

  // Handshake rule: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and both are
  // decoded from the state register so no input reaches an output combinationally.

  localparam int K_W = $clog2(WIDTH);

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] x_nx;
  logic [WIDTH-1:0] y_nx;
  logic             xy_eq;

  gcd_stein_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .x   (x_q),
    .y   (y_q),
    .x_nx(x_nx),
    .y_nx(y_nx),
    .eq  (xy_eq)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d = in_a;
          y_d = in_b;
          k_d = '0;
          if ((in_a == '0) || (in_b == '0)) begin
            result_d = in_a | in_b;
            state_d  = DONE;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + K_W'(1);
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (xy_eq) begin
          state_d = FINISH;
        end else begin
          x_d = x_nx;
          y_d = y_nx;
        end
      end
      FINISH: begin
        // Restore the common power of two stripped during ALIGN.
        result_d = x_q << k_q;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_gcd   = result_q;

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) && in_valid) begin
      cnt_d = '0;
    end else if (((state_q == ALIGN) || (state_q == REDUCE) || (state_q == FINISH))
                 && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_stein_engine.sv
// Bench for gcd_stein_engine: directed WIDTH=8 cases and randomized WIDTH=16
// pairs against a Euclid reference model. Cycle-count checks need GCD_CYCLE_COUNT_EN.
module tb_gcd_stein_engine;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   in_valid;
  logic [1:0]   out_ready;
  logic [1:0]   in_ready_w;
  logic [1:0]   out_valid_w;
  logic [W-1:0] in_a, in_b;
  logic [7:0]   gcd8;
  logic [15:0]  gcd16;
`ifdef GCD_CYCLE_COUNT_EN
  logic [4:0]   cyc8;
  logic [5:0]   cyc16;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  gcd_stein_engine #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid[0]),
    .in_ready (in_ready_w[0]),
    .in_a     (in_a[7:0]),
    .in_b     (in_b[7:0]),
    .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]),
    .out_gcd  (gcd8)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .out_cycles(cyc8)
`endif
  );

  gcd_stein_engine #(.WIDTH(16)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid[1]),
    .in_ready (in_ready_w[1]),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]),
    .out_gcd  (gcd16)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .out_cycles(cyc16)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [W-1:0] obs_gcd(input int u);
    return (u != 0) ? gcd16 : {8'h00, gcd8};
  endfunction

`ifdef GCD_CYCLE_COUNT_EN
  function automatic logic [31:0] obs_cyc(input int u);
    return (u != 0) ? {26'd0, cyc16} : {27'd0, cyc8};
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int u, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (!in_ready_w[u] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready", {31'd0, in_ready_w[u]}, 32'd1);
    in_a = a;
    in_b = b;
    in_valid[u] = 1'b1;
    exp_q.push_back(ref_gcd(a, b));
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  // Latency counts rising edges from acceptance to out_valid.
  task automatic wait_result(input int u, input string tag, output int lat);
    logic [W-1:0] e;
    lat = 1;
    while (!out_valid_w[u] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, {31'd0, out_valid_w[u]}, 32'd1);
    e = exp_q.pop_front();
    check(tag, {16'd0, obs_gcd(u)}, {16'd0, e});
  endtask

  task automatic accept_result(input int u);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check("ready_after_out", {31'd0, in_ready_w[u]}, 32'd1);
    check("valid_after_out", {31'd0, out_valid_w[u]}, 32'd0);
  endtask

  task automatic do_pair(input int u, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input int exp_lat, input int exp_cyc,
                         input int hold);
    int lat;
    int w;
    w = (u != 0) ? 16 : 8;
    issue(u, a, b);
    wait_result(u, tag, lat);
    if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
    else check({tag, "_lat_bound"}, {31'd0, lat <= 3 * w + 3}, 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
    check({tag, "_cycles"}, obs_cyc(u), (exp_cyc >= 0) ? exp_cyc : lat - 1);
`else
    if (exp_cyc > lat) check({tag, "_cyc_plan"}, exp_cyc, lat);
`endif
    repeat (hold) @(negedge clk);
    accept_result(u);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] g;
    logic [W-1:0] ra, rb;
    int lat;
    in_valid  = '0;
    out_ready = '0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_in_ready8", {31'd0, in_ready_w[0]}, 32'd1);
    check("rst_out_valid8", {31'd0, out_valid_w[0]}, 32'd0);
    check("rst_out_gcd8", {24'd0, gcd8}, 32'd0);
    check("rst_in_ready16", {31'd0, in_ready_w[1]}, 32'd1);
`ifdef GCD_CYCLE_COUNT_EN
    check("rst_cycles8", obs_cyc(0), 32'd0);
`endif

    // Directed WIDTH=8: (4,6) takes ALIGN 2, REDUCE 3, FINISH 1.
    do_pair(0, 16'd4,   16'd6,   "g_4_6",     7, 6, 0);
    do_pair(0, 16'd48,  16'd18,  "g_48_18",   0, -1, 0);
    do_pair(0, 16'd17,  16'd13,  "g_17_13",   0, -1, 1);
    do_pair(0, 16'd255, 16'd255, "g_255_255", 0, -1, 0);
    do_pair(0, 16'd0,   16'd35,  "g_0_35",    1, 0, 0);
    do_pair(0, 16'd35,  16'd0,   "g_35_0",    1, 0, 2);
    do_pair(0, 16'd0,   16'd0,   "g_0_0",     1, 0, 0);

    // Backpressure: result must hold while out_ready is low.
    issue(0, 16'd12, 16'd8);
    wait_result(0, "bp_first", lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid_w[0]}, 32'd1);
      check("bp_gcd", {24'd0, gcd8}, 32'd4);
      check("bp_in_ready", {31'd0, in_ready_w[0]}, 32'd0);
    end
    accept_result(0);

    // New operands during REDUCE are ignored.
    issue(0, 16'd48, 16'd18);
    repeat (2) @(negedge clk);
    in_a = 16'd7;
    in_b = 16'd5;
    in_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    in_valid[0] = 1'b0;
    wait_result(0, "ignore_inval", lat);
    accept_result(0);

    // Reset mid-REDUCE discards the operation.
    issue(0, 16'd200, 16'd150);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    g = exp_q.pop_back();
    check("midrst_in_ready", {31'd0, in_ready_w[0]}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid_w[0]}, 32'd0);
    check("midrst_out_gcd", {24'd0, gcd8}, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_still_idle", {31'd0, out_valid_w[0]}, 32'd0);
    do_pair(0, 16'd200, 16'd150, "g_200_150", 0, -1, 0);

    // Randomized WIDTH=16.
    do_pair(1, 16'd1024, 16'd4096, "g_1024_4096", 0, -1, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535) << $urandom_range(0, 4));
      rb = 16'($urandom_range(0, 65535) << $urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) ra = '0;
      if ($urandom_range(0, 19) == 0) rb = '0;
      do_pair(1, ra, rb, "rand16", 0, -1, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
